vlg_design: RTL and testbench

VLG_DESIGN -- requirements
Module: vlg_design

---
 rtl/vlg_design_pkg.sv | 11 +
 rtl/vlg_design_pwm_period_counter.sv | 27 ++
 rtl/vlg_design.sv | 81 ++++++++
 tb/tb_vlg_design.sv | 139 +++++++++++++
 4 files changed

// File: rtl/vlg_design_pkg.sv
// Shared types and widths for the burst PWM generator.
package vlg_design_pkg;
   localparam int PERIOD_W = 32;
   localparam int TIMES_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/vlg_design_pwm_period_counter.sv
// Cycle counter within one PWM period: wraps at period-1, flags the high phase.
module pwm_period_counter
   import vlg_design_pkg::*;
(
   input  logic                clk_sys,
   input  logic                rst_b,
   input  logic                clear,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic [PERIOD_W-1:0] high,
   output logic                wrap,
   output logic                high_flag
);
   logic [PERIOD_W-1:0] cnt;

   assign wrap      = enable && (cnt == (period - PERIOD_W'(1)));
   assign high_flag = (cnt < high);

   always_ff @(posedge clk_sys) begin
      if (!rst_b || clear)
         cnt <= '0;
      else if (wrap)
         cnt <= '0;
      else if (enable)
         cnt <= cnt + PERIOD_W'(1);
   end
endmodule

// File: rtl/vlg_design.sv
// Burst PWM generator: emits 'times' periods of a latched period/high pattern.
//   state | meaning
//   IDLE  | waiting for i_en=1; parameters latched on the starting edge
//   RUN   | burst in progress, o_pwm follows the cycle counter
//   DONE  | burst finished, o_pwm=0 until i_en returns low
module vlg_design
   import vlg_design_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_en,
   input  logic [PERIOD_W-1:0] i_periord,
   input  logic [PERIOD_W-1:0] i_high,
   input  logic [TIMES_W-1:0]  i_times,
   output logic                o_pwm
);
   state_t              state, state_nxt;
   logic [PERIOD_W-1:0] period_lat, high_lat;
   logic [TIMES_W-1:0]  times_lat, per_cnt;
   logic                load, wrap, high_flag, last;

   assign load = (state == IDLE) && i_en;
   assign last = wrap && (per_cnt == (times_lat - TIMES_W'(1)));

   pwm_period_counter u_cnt (
      .clk_sys   (i_clk),
      .rst_b     (i_rst_n),
      .clear     (state != RUN),
      .enable    (state == RUN),
      .period    (period_lat),
      .high      (high_lat),
      .wrap      (wrap),
      .high_flag (high_flag)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         period_lat <= '0;
         high_lat   <= '0;
         times_lat  <= '0;
      end else if (load) begin
         period_lat <= i_periord;
         high_lat   <= i_high;
         times_lat  <= i_times;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || state != RUN)
         per_cnt <= '0;
      else if (wrap)
         per_cnt <= per_cnt + TIMES_W'(1);
   end

   // Degenerate bursts (zero period or zero count) skip RUN entirely.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (i_en) state_nxt = (i_periord == '0 || i_times == '0) ? DONE : RUN;
         RUN: begin
            if (!i_en)     state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE: if (!i_en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_pwm = 1'b0;
      if (state == RUN)
         o_pwm = high_flag;
   end
endmodule

// File: tb/tb_vlg_design.sv
// Scoreboard bench for the burst PWM generator: stimulus queues the expected
// o_pwm after each edge, a monitor compares at the following falling edge.
module tb_vlg_design;
   import vlg_design_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_en;
   logic [31:0] i_periord;
   logic [31:0] i_high;
   logic [15:0] i_times;
   logic        o_pwm;

   int   nvec = 0;
   int   nerr = 0;
   logic exp_q[$];

   vlg_design dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (i_en),
      .i_periord (i_periord),
      .i_high    (i_high),
      .i_times   (i_times),
      .o_pwm     (o_pwm)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      logic e;
      forever begin
         @(negedge i_clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nvec++;
            if (o_pwm !== e) begin
               nerr++;
               $display("FAIL pwm vec %0d t=%0t: got %b want %b", nvec, $time, o_pwm, e);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // Inputs set before the call are sampled at this edge; exp is o_pwm after it.
   task automatic tick(input logic exp);
      @(posedge i_clk);
      #1;
      exp_q.push_back(exp);
   endtask

   // Holds i_en for 'hold' edges (first is the load edge), optionally changing
   // i_high after the load, then drops i_en. Expectation after edge j of the
   // burst: j < P*T ? (j mod P) < H : 0.
   task automatic burst(input longint p, input longint h, input longint t,
                        input int hold, input bit wiggle);
      i_en      = 1'b1;
      i_periord = 32'(p);
      i_high    = 32'(h);
      i_times   = 16'(t);
      for (int j = 0; j < hold; j++) begin
         tick((longint'(j) < p * t) ? ((longint'(j) % p) < h) : 1'b0);
         if (wiggle) begin
            i_high    = 32'($urandom);
            i_periord = 32'($urandom_range(1, 50));
            i_times   = 16'($urandom_range(1, 9));
         end
      end
      i_en = 1'b0;
      tick(1'b0);
      tick(1'b0);
   endtask

   initial begin
      i_rst_n = 1'b0; i_en = 1'b0; i_periord = '0; i_high = '0; i_times = '0;
      for (int k = 0; k < 50; k++) begin
         i_en      = 1'($urandom);
         i_periord = 32'($urandom_range(0, 20));
         i_high    = 32'($urandom_range(0, 20));
         i_times   = 16'($urandom_range(0, 5));
         tick(1'b0);
      end
      i_en = 1'b0;
      i_rst_n = 1'b1;
      tick(1'b0);
      nvec++;
      if (dut.state !== IDLE) begin
         nerr++;
         $display("FAIL state_after_reset: got %0d want %0d", dut.state, IDLE);
      end
      tick(1'b0);

      burst(2500, 250, 3, 7500, 1'b0);
      burst(1000, 500, 5, 5000, 1'b1);
      burst(1000, 500, 5, 100, 1'b0);   // abort at cycle 100
      burst(1000, 500, 5, 1200, 1'b0);  // fresh burst starts at period 1
      burst(10, 10, 2, 40, 1'b0);       // constant high, en held past DONE
      burst(10, 0, 2, 30, 1'b0);
      burst(0, 5, 3, 20, 1'b0);
      burst(10, 5, 0, 20, 1'b0);
      burst(7, 200, 3, 30, 1'b0);       // high beyond period
      burst(4, 1, 3, 16, 1'b0);

      i_en = 1'b1; i_periord = 32'd10; i_times = 16'd0; i_high = 32'd3;
      tick(1'b0);
      nvec++;
      if (dut.state !== DONE) begin
         nerr++;
         $display("FAIL zero_times_done: got %0d want %0d", dut.state, DONE);
      end
      i_en = 1'b0;
      tick(1'b0);

      // Reset during a high phase, then restart only on a new sampled i_en.
      i_en = 1'b1; i_periord = 32'd1000; i_high = 32'd500; i_times = 16'd5;
      for (int j = 0; j < 200; j++) tick(1'b1);
      i_rst_n = 1'b0;
      tick(1'b0);
      tick(1'b0);
      i_rst_n = 1'b1; i_en = 1'b0;
      for (int j = 0; j < 5; j++) tick(1'b0);
      burst(20, 7, 2, 45, 1'b0);

      @(negedge i_clk);
      #1;
      if (exp_q.size() != 0) begin
         nerr++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
